drive_controller: RTL and testbench
===================================

DRIVE_CONTROLLER -- requirements
Module: drive_controller

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive identical sensor samples required before a pattern is accepted.
REQ-002 Parameter TURN_CYCLES, default 1000: number of cycles a ninety-degree turn stays locked.
REQ-003 Parameter LOST_CYCLES, default 5000: consecutive accepted all-zero cycles before the block stops.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 enable  input  1  run request; 0 forces IDLE.
REQ-007 lineSensor  input  5  line detectors, 1 = line seen; bit 4 is leftmost, bit 2 is centre.
REQ-008 fullSpeedPwm, veerSpeedPwm, hardSpeedPwm, ninetySpeedPwm, ninetyFastSpeedPwm  input  1 each  duty-cycle sources from the PWM generator.
REQ-009 leftPwm, rightPwm  output  1 each  motor drive pulses.
REQ-010 leftDir, rightDir  output  1 each  motor direction; 1 = forward.
REQ-011 driveState  output  4  current FSM state encoding.
REQ-012 turnActive  output  1  high while in TURN90_LEFT or TURN90_RIGHT.

Function
REQ-013 The block SHALL have these FSM states: IDLE, FORWARD, VEER_L, VEER_R, HARD_L, HARD_R, TURN90_LEFT, TURN90_RIGHT, STOP.
REQ-014 The debouncer SHALL count identical consecutive lineSensor samples, saturating at DEBOUNCE_CYCLES; any change SHALL restart the count at 1; a pattern is accepted while the count equals DEBOUNCE_CYCLES.
REQ-015 The accepted pattern SHALL decode as follows: 00100 -> FORWARD; 01100/01000 -> VEER_L; 00110/00010 -> VEER_R; 10000/11000 -> HARD_L; 00001/00011 -> HARD_R; 11100/11110 -> TURN90_LEFT; 00111/01111 -> TURN90_RIGHT; 00000 -> lost; any other pattern -> hold the current state.
REQ-016 IDLE with enable=1 SHALL go to FORWARD on the next edge.
REQ-017 From FORWARD, VEER or HARD states, the FSM SHALL move to the decoded state on the edge after the pattern is accepted.
REQ-018 Entering a TURN90 state SHALL load the turn counter with TURN_CYCLES-1; sensors SHALL be ignored until the counter reaches 0; the next edge after that SHALL go to FORWARD.
REQ-019 The lost counter SHALL increment each cycle the accepted pattern is 00000 outside IDLE, STOP and TURN90, and SHALL clear on any other accepted pattern; reaching LOST_CYCLES-1 SHALL go to STOP.
REQ-020 STOP SHALL exit to FORWARD only on accepted 00100; other patterns SHALL hold STOP.
REQ-021 enable=0 SHALL force IDLE on the next edge from any state, including a locked turn; this clears the turn and lost counters.
REQ-022 Output mapping from the registered state, with one cycle of latency:
  - FORWARD: L=full, R=full.
  - VEER_L: L=veer, R=full.
  - VEER_R: L=full, R=veer.
  - HARD_L: L=hard, R=full.
  - HARD_R: L=full, R=hard.
  - TURN90_LEFT: L=ninety with leftDir=0, R=ninetyFast.
  - TURN90_RIGHT: L=ninetyFast, R=ninety with rightDir=0.
  - IDLE/STOP: both 0.
  - Dir=1 in all cases except the two reversed turn wheels above.
REQ-023 The PWM outputs SHALL be the selected input AND a registered select; they SHALL be glitch-free with respect to a state change.
REQ-024 The counters SHALL be sized with $clog2 of their parameter and SHALL never wrap.

Reset
REQ-025 rst=1 SHALL asynchronously force: state IDLE, all counters 0, leftPwm=rightPwm=0, leftDir=rightDir=1, turnActive=0, driveState=IDLE encoding.
REQ-026 Reset asserted mid-turn or in STOP SHALL behave identically to reset from IDLE; operation resumes on the first edge after release.

Structure
REQ-027 State encodings and the sensor pattern constants SHALL live in a shared package, drive_pkg.
REQ-028 The debouncer SHALL be a sub-module, line_sensor_debounce, with outputs for the accepted pattern and a valid flag.

Verification
REQ-029 rst pulse mid-operation -> all outputs at reset values immediately; with enable=1, driveState=FORWARD two edges after release.
REQ-030 Sensor 01000 held 4 cycles from FORWARD -> VEER_L on edge 5; leftPwm follows veerSpeedPwm one cycle later; a 3-cycle glitch produces no transition.
REQ-031 Sensor 11100 accepted -> TURN90_LEFT with leftDir=0 and turnActive=1 for exactly 1000 cycles despite sensor changes, then FORWARD.
REQ-032 Sensor 00000 for DEBOUNCE+5000 cycles -> STOP with outputs 0; 10101 holds STOP; accepted 00100 -> FORWARD.
REQ-033 enable dropped at cycle 500 of a turn -> IDLE next edge with outputs 0; re-enable -> FORWARD with a fresh turn counter.

Source files
------------

// File: rtl/drive_pkg.sv
// drive_pkg: shared state encodings, sensor pattern constants and the
// sensor-pattern decoder used by the drive controller.
package drive_pkg;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE         = 4'd0;
    localparam logic [STATE_W-1:0] ST_FORWARD      = 4'd1;
    localparam logic [STATE_W-1:0] ST_VEER_L       = 4'd2;
    localparam logic [STATE_W-1:0] ST_VEER_R       = 4'd3;
    localparam logic [STATE_W-1:0] ST_HARD_L       = 4'd4;
    localparam logic [STATE_W-1:0] ST_HARD_R       = 4'd5;
    localparam logic [STATE_W-1:0] ST_TURN90_LEFT  = 4'd6;
    localparam logic [STATE_W-1:0] ST_TURN90_RIGHT = 4'd7;
    localparam logic [STATE_W-1:0] ST_STOP         = 4'd8;

    // bit 4 = leftmost detector, bit 2 = centre
    localparam logic [4:0] PAT_LOST     = 5'b00000;
    localparam logic [4:0] PAT_CENTRE   = 5'b00100;
    localparam logic [4:0] PAT_VEER_L0  = 5'b01100;
    localparam logic [4:0] PAT_VEER_L1  = 5'b01000;
    localparam logic [4:0] PAT_VEER_R0  = 5'b00110;
    localparam logic [4:0] PAT_VEER_R1  = 5'b00010;
    localparam logic [4:0] PAT_HARD_L0  = 5'b10000;
    localparam logic [4:0] PAT_HARD_L1  = 5'b11000;
    localparam logic [4:0] PAT_HARD_R0  = 5'b00001;
    localparam logic [4:0] PAT_HARD_R1  = 5'b00011;
    localparam logic [4:0] PAT_TURN_L0  = 5'b11100;
    localparam logic [4:0] PAT_TURN_L1  = 5'b11110;
    localparam logic [4:0] PAT_TURN_R0  = 5'b00111;
    localparam logic [4:0] PAT_TURN_R1  = 5'b01111;

    typedef enum logic [2:0] {
        SEL_OFF,
        SEL_FULL,
        SEL_VEER,
        SEL_HARD,
        SEL_NINETY,
        SEL_FAST
    } pwm_sel_e;

    // known=0 means "unrecognised pattern, hold state"; lost=1 means all-zero
    typedef struct packed {
        logic                 known;
        logic                 lost;
        logic [STATE_W-1:0]   state;
    } decode_t;

    function automatic decode_t decode_pattern(input logic [4:0] pat);
        decode_t d;
        d.known = 1'b1;
        d.lost  = 1'b0;
        d.state = ST_FORWARD;
        case (pat)
            PAT_CENTRE:               d.state = ST_FORWARD;
            PAT_VEER_L0, PAT_VEER_L1: d.state = ST_VEER_L;
            PAT_VEER_R0, PAT_VEER_R1: d.state = ST_VEER_R;
            PAT_HARD_L0, PAT_HARD_L1: d.state = ST_HARD_L;
            PAT_HARD_R0, PAT_HARD_R1: d.state = ST_HARD_R;
            PAT_TURN_L0, PAT_TURN_L1: d.state = ST_TURN90_LEFT;
            PAT_TURN_R0, PAT_TURN_R1: d.state = ST_TURN90_RIGHT;
            PAT_LOST:                 d.lost  = 1'b1;
            default:                  d.known = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/line_sensor_debounce.sv
// line_sensor_debounce: accepts a line-sensor pattern once it has been
// sampled identically DEBOUNCE_CYCLES times in a row.
//   clk, rst    : clock, async active-high reset
//   sample_i    : raw sensor pattern
//   pattern_o   : last sampled pattern
//   valid_o     : high while pattern_o is accepted
module line_sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] sample_i,
    output logic [4:0] pattern_o,
    output logic       valid_o
);
    // the count has to reach DEBOUNCE_CYCLES itself, hence the +1
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic [4:0]    last_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= '0;
            cnt_q  <= '0;
        end else if (sample_i != last_q) begin
            last_q <= sample_i;
            cnt_q  <= CW'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_q  <= cnt_q + CW'(1);
        end
    end

    assign pattern_o = last_q;
    assign valid_o   = (cnt_q == CNT_MAX);

endmodule

// File: rtl/drive_controller.sv
// drive_controller: line-following motor drive FSM.
//   clk, rst           : clock, async active-high reset
//   enable             : run request, 0 forces IDLE
//   lineSensor[4:0]    : line detectors (bit 4 leftmost, bit 2 centre)
//   *SpeedPwm          : duty-cycle sources from the PWM generator
//   leftPwm, rightPwm  : motor drive pulses
//   leftDir, rightDir  : motor direction, 1 = forward
//   driveState[3:0]    : current FSM state
//   turnActive         : high while in a ninety-degree turn
//
// state           | meaning
// IDLE            | not enabled, motors off
// FORWARD         | centred on line, both wheels full
// VEER_L / VEER_R | slight correction, inner wheel at veer speed
// HARD_L / HARD_R | strong correction, inner wheel at hard speed
// TURN90_LEFT/RT  | locked pivot for TURN_CYCLES, sensors ignored
// STOP            | line lost, waits for centred pattern
module drive_controller
    import drive_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TURN_CYCLES     = 1000,
    parameter int LOST_CYCLES     = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [4:0] lineSensor,
    input  logic       fullSpeedPwm,
    input  logic       veerSpeedPwm,
    input  logic       hardSpeedPwm,
    input  logic       ninetySpeedPwm,
    input  logic       ninetyFastSpeedPwm,
    output logic       leftPwm,
    output logic       rightPwm,
    output logic       leftDir,
    output logic       rightDir,
    output logic [3:0] driveState,
    output logic       turnActive
);
    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam int LW = (LOST_CYCLES > 1) ? $clog2(LOST_CYCLES) : 1;
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYCLES - 1);
    localparam logic [LW-1:0] LOST_LAST = LW'(LOST_CYCLES - 1);

    logic [4:0]         pat;
    logic               pat_valid;
    decode_t            dec;

    logic [STATE_W-1:0] state_q, state_d;
    logic [TW-1:0]      turn_q, turn_d;
    logic [LW-1:0]      lost_q, lost_d;

    pwm_sel_e           lsel_q, lsel_d, rsel_q, rsel_d;
    logic               ldir_q, ldir_d, rdir_q, rdir_d;

    line_sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .sample_i  (lineSensor),
        .pattern_o (pat),
        .valid_o   (pat_valid)
    );

    assign dec = decode_pattern(pat);

    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        lost_d  = lost_q;
        if (!enable) begin
            state_d = ST_IDLE;
            turn_d  = '0;
            lost_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_FORWARD;
                    turn_d  = '0;
                    lost_d  = '0;
                end
                ST_FORWARD, ST_VEER_L, ST_VEER_R, ST_HARD_L, ST_HARD_R: begin
                    if (pat_valid) begin
                        if (dec.lost) begin
                            if (lost_q == LOST_LAST) begin
                                state_d = ST_STOP;
                                lost_d  = '0;
                            end else begin
                                lost_d  = lost_q + LW'(1);
                            end
                        end else begin
                            // any non-zero accepted pattern, even unknown, ends a loss run
                            lost_d = '0;
                            if (dec.known) begin
                                state_d = dec.state;
                                if (dec.state == ST_TURN90_LEFT || dec.state == ST_TURN90_RIGHT)
                                    turn_d = TURN_LOAD;
                            end
                        end
                    end
                end
                ST_TURN90_LEFT, ST_TURN90_RIGHT: begin
                    lost_d = '0;
                    if (turn_q == '0)
                        state_d = ST_FORWARD;
                    else
                        turn_d = turn_q - TW'(1);
                end
                ST_STOP: begin
                    lost_d = '0;
                    if (pat_valid && pat == PAT_CENTRE)
                        state_d = ST_FORWARD;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        lsel_d = SEL_OFF;
        rsel_d = SEL_OFF;
        ldir_d = 1'b1;
        rdir_d = 1'b1;
        case (state_q)
            ST_FORWARD:      begin lsel_d = SEL_FULL;   rsel_d = SEL_FULL;   end
            ST_VEER_L:       begin lsel_d = SEL_VEER;   rsel_d = SEL_FULL;   end
            ST_VEER_R:       begin lsel_d = SEL_FULL;   rsel_d = SEL_VEER;   end
            ST_HARD_L:       begin lsel_d = SEL_HARD;   rsel_d = SEL_FULL;   end
            ST_HARD_R:       begin lsel_d = SEL_FULL;   rsel_d = SEL_HARD;   end
            ST_TURN90_LEFT:  begin lsel_d = SEL_NINETY; rsel_d = SEL_FAST; ldir_d = 1'b0; end
            ST_TURN90_RIGHT: begin lsel_d = SEL_FAST;   rsel_d = SEL_NINETY; rdir_d = 1'b0; end
            default:         ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            turn_q  <= '0;
            lost_q  <= '0;
            lsel_q  <= SEL_OFF;
            rsel_q  <= SEL_OFF;
            ldir_q  <= 1'b1;
            rdir_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            lost_q  <= lost_d;
            lsel_q  <= lsel_d;
            rsel_q  <= rsel_d;
            ldir_q  <= ldir_d;
            rdir_q  <= rdir_d;
        end
    end

    // Select is registered, so the AND-mux only passes source edges, never a decode glitch.
    function automatic logic pwm_pick(input pwm_sel_e sel);
        logic p;
        p = 1'b0;
        case (sel)
            SEL_FULL:   p = fullSpeedPwm;
            SEL_VEER:   p = veerSpeedPwm;
            SEL_HARD:   p = hardSpeedPwm;
            SEL_NINETY: p = ninetySpeedPwm;
            SEL_FAST:   p = ninetyFastSpeedPwm;
            default:    p = 1'b0;
        endcase
        return p;
    endfunction

    assign leftPwm    = pwm_pick(lsel_q);
    assign rightPwm   = pwm_pick(rsel_q);
    assign leftDir    = ldir_q;
    assign rightDir   = rdir_q;
    assign driveState = state_q;
    assign turnActive = (state_q == ST_TURN90_LEFT) || (state_q == ST_TURN90_RIGHT);

endmodule

// File: tb/tb_drive_controller.sv
module tb_drive_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [4:0] lineSensor;
    logic       fullSpeedPwm, veerSpeedPwm, hardSpeedPwm, ninetySpeedPwm, ninetyFastSpeedPwm;
    logic       leftPwm, rightPwm, leftDir, rightDir, turnActive;
    logic [3:0] driveState;

    int errors = 0;
    int checks = 0;
    int cnt;

    localparam logic [3:0] S_IDLE = 4'd0, S_FWD = 4'd1, S_VEER_L = 4'd2,
                           S_TURN_L = 4'd6, S_TURN_R = 4'd7, S_STOP = 4'd8;

    drive_controller dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .lineSensor         (lineSensor),
        .fullSpeedPwm       (fullSpeedPwm),
        .veerSpeedPwm       (veerSpeedPwm),
        .hardSpeedPwm       (hardSpeedPwm),
        .ninetySpeedPwm     (ninetySpeedPwm),
        .ninetyFastSpeedPwm (ninetyFastSpeedPwm),
        .leftPwm            (leftPwm),
        .rightPwm           (rightPwm),
        .leftDir            (leftDir),
        .rightDir           (rightDir),
        .driveState         (driveState),
        .turnActive         (turnActive)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // order: full, veer, hard, ninety, fast
    task automatic set_src(input logic [4:0] s);
        {fullSpeedPwm, veerSpeedPwm, hardSpeedPwm, ninetySpeedPwm, ninetyFastSpeedPwm} = s;
        #1;
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        lineSensor = 5'b00100;
        set_src(5'b11111);
        #21;
        check("rst_state", 32'(driveState), 32'(S_IDLE));
        check("rst_lpwm", 32'(leftPwm), 0);
        check("rst_rpwm", 32'(rightPwm), 0);
        check("rst_ldir", 32'(leftDir), 1);
        check("rst_rdir", 32'(rightDir), 1);
        check("rst_turn", 32'(turnActive), 0);

        rst = 1'b0;
        enable = 1'b1;
        step(2);
        check("start_fwd", 32'(driveState), 32'(S_FWD));
        check("fwd_lpwm_full", 32'(leftPwm), 1);
        set_src(5'b01111);
        check("fwd_lpwm_full0", 32'(leftPwm), 0);
        check("fwd_rpwm_full0", 32'(rightPwm), 0);

        // 3-cycle glitch must not move the FSM
        lineSensor = 5'b01000;
        step(3);
        lineSensor = 5'b00100;
        step(5);
        check("glitch_hold", 32'(driveState), 32'(S_FWD));

        lineSensor = 5'b01000;
        step(4);
        check("veer_not_yet", 32'(driveState), 32'(S_FWD));
        step(1);
        check("veer_edge5", 32'(driveState), 32'(S_VEER_L));
        set_src(5'b10111);
        check("veer_latency", 32'(leftPwm), 1);
        step(1);
        check("veer_lpwm0", 32'(leftPwm), 0);
        check("veer_rpwm_full1", 32'(rightPwm), 1);
        set_src(5'b01000);
        check("veer_lpwm1", 32'(leftPwm), 1);
        check("veer_rpwm_full0", 32'(rightPwm), 0);

        // locked left turn
        lineSensor = 5'b11100;
        step(5);
        check("turnL_enter", 32'(driveState), 32'(S_TURN_L));
        check("turnL_active", 32'(turnActive), 1);
        lineSensor = 5'b00111;
        set_src(5'b00010);
        step(1);
        check("turnL_ldir", 32'(leftDir), 0);
        check("turnL_rdir", 32'(rightDir), 1);
        check("turnL_lpwm_ninety", 32'(leftPwm), 1);
        check("turnL_rpwm_fast", 32'(rightPwm), 0);
        cnt = 2;
        while (turnActive && cnt < 3000) begin
            step(1);
            if (turnActive) cnt++;
            if (cnt == 200) lineSensor = 5'b00100;
        end
        check("turnL_len", 32'(cnt), 1000);
        check("turnL_exit", 32'(driveState), 32'(S_FWD));
        step(2);
        check("turnL_ldir_back", 32'(leftDir), 1);

        // lost line
        set_src(5'b11111);
        lineSensor = 5'b00000;
        cnt = 0;
        while (driveState != S_STOP && cnt < 6000) begin
            step(1);
            cnt++;
        end
        check("lost_edges", 32'(cnt), 5004);
        step(1);
        check("stop_lpwm", 32'(leftPwm), 0);
        check("stop_rpwm", 32'(rightPwm), 0);
        lineSensor = 5'b10101;
        step(6);
        check("stop_hold_10101", 32'(driveState), 32'(S_STOP));
        lineSensor = 5'b01000;
        step(6);
        check("stop_hold_veer", 32'(driveState), 32'(S_STOP));
        lineSensor = 5'b00100;
        step(4);
        check("stop_not_yet", 32'(driveState), 32'(S_STOP));
        step(1);
        check("stop_exit", 32'(driveState), 32'(S_FWD));

        // enable dropped mid-turn
        lineSensor = 5'b00111;
        step(5);
        check("turnR_enter", 32'(driveState), 32'(S_TURN_R));
        set_src(5'b00010);
        step(1);
        check("turnR_rdir", 32'(rightDir), 0);
        check("turnR_rpwm_ninety", 32'(rightPwm), 1);
        step(498);
        enable = 1'b0;
        step(1);
        check("dis_idle", 32'(driveState), 32'(S_IDLE));
        check("dis_turn", 32'(turnActive), 0);
        set_src(5'b11111);
        step(1);
        check("dis_lpwm", 32'(leftPwm), 0);
        check("dis_rpwm", 32'(rightPwm), 0);
        check("dis_rdir", 32'(rightDir), 1);
        enable = 1'b1;
        step(1);
        check("reen_fwd", 32'(driveState), 32'(S_FWD));
        step(1);
        check("reen_turnR", 32'(driveState), 32'(S_TURN_R));
        lineSensor = 5'b00100;
        cnt = 1;
        while (turnActive && cnt < 3000) begin
            step(1);
            if (turnActive) cnt++;
        end
        check("reen_turn_len", 32'(cnt), 1000);
        check("reen_turn_exit", 32'(driveState), 32'(S_FWD));

        // reset in the middle of a turn
        lineSensor = 5'b11100;
        step(5);
        check("turnL2_enter", 32'(driveState), 32'(S_TURN_L));
        step(3);
        check("turnL2_ldir", 32'(leftDir), 0);
        rst = 1'b1;
        #1;
        check("mrst_state", 32'(driveState), 32'(S_IDLE));
        check("mrst_ldir", 32'(leftDir), 1);
        check("mrst_lpwm", 32'(leftPwm), 0);
        check("mrst_rpwm", 32'(rightPwm), 0);
        check("mrst_turn", 32'(turnActive), 0);
        lineSensor = 5'b00100;
        #10;
        rst = 1'b0;
        step(2);
        check("mrst_fwd", 32'(driveState), 32'(S_FWD));
        step(6);
        check("mrst_fwd_hold", 32'(driveState), 32'(S_FWD));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
